// File: rtl/pio_input_edge_irq.sv
// Input-only Avalon-MM PIO: synchronises in_port, captures edges into a sticky register
// and raises a level irq. Define PIO_DEBOUNCE_EN to add per-bit debounce counters.
module pio_input_edge_irq #(
  parameter int WIDTH           = 5,
  parameter int EDGE_TYPE       = 1,
  parameter int RESET_SETTLE    = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_stab;
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_settle;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_edge_new;
  logic [31:0]      w_rd_next;
  logic             w_unused;

  // Upper writedata bits are don't-care for narrow configurations.
  assign w_unused = ^{writedata, 32'(DEBOUNCE_CYCLES)};

  // NOTE: state registers use <= so every flop samples pre-edge values, whatever the block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_db_cnt [WIDTH];
  logic [WIDTH-1:0] r_stab;

  // NOTE: the counter array is plain flops, not RAM, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) r_db_cnt[i] <= '0;
      r_stab <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stab[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CNT_LAST) begin
          r_stab[i]   <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_stab = r_stab;
`else
  assign w_stab = r_sync2;
`endif

  // Settle window hides the apparent rise of inputs that are already high out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle <= 4'(RESET_SETTLE);
      r_prev   <= '0;
    end else begin
      r_prev <= w_stab;
      if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
    end
  end

  assign w_rise  = w_stab & ~r_prev;
  assign w_fall  = ~w_stab & r_prev;
  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];
  assign w_clr   = (w_wr && address == ADDR_EDGE) ? w_wdata : '0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      1:       w_edge = w_rise;
      2:       w_edge = w_fall;
      3:       w_edge = w_rise | w_fall;
      default: w_edge = '0;
    endcase
    w_edge_new = (r_settle == 4'd0) ? w_edge : '0;
  end

  always_comb begin
    w_rd_next = '0;
    case (address)
      ADDR_DATA: w_rd_next = 32'(w_stab);
      ADDR_MASK: w_rd_next = 32'(r_irq_mask);
      ADDR_EDGE: w_rd_next = 32'(r_edge_cap);
      default:   w_rd_next = '0;
    endcase
  end

  // A new edge is ORed in after the clear, so it wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && address == ADDR_MASK) r_irq_mask <= w_wdata;
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge_new;
      r_readdata <= w_rd_next;
      r_irq      <= |(r_edge_cap & r_irq_mask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Bench for pio_input_edge_irq: a rising-edge and an any-edge instance share one stimulus
// and are compared each cycle against a history-based model, plus literal spot checks.
module tb_pio_input_edge_irq;

  localparam int W  = 5;
  localparam int RS = 3;
  localparam int DB = 16;
  localparam int N  = 4096;
`ifdef PIO_DEBOUNCE_EN
  localparam int EDGE_LAT = 2 + DB;
`else
  localparam int EDGE_LAT = 2;
`endif

  logic         clk;
  logic         reset;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  rd_a, rd_b;
  logic         irq_a, irq_b;

  int checks   = 0;
  int failures = 0;

  pio_input_edge_irq #(.WIDTH(W), .EDGE_TYPE(1), .RESET_SETTLE(RS), .DEBOUNCE_CYCLES(DB)) u_dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a));

  pio_input_edge_irq #(.WIDTH(W), .EDGE_TYPE(3), .RESET_SETTLE(RS), .DEBOUNCE_CYCLES(DB)) u_dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_port), .irq(irq_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: per-cycle histories indexed by clock edge number ----------------
  logic [W-1:0] m_hist [N];
  logic [W-1:0] m_sync [N];
  logic [W-1:0] m_stab [N];
  logic [W-1:0] m_mask [N];
  logic [W-1:0] m_cap  [2][N];
  logic [31:0]  m_rd   [2][N];
  logic         m_irq  [2][N];
  int           n        = 0;
  int           last_rst = 0;
  int           last_flip [W];
  bit           model_valid = 1'b0;

  function automatic logic [W-1:0] edges(input int et, input logic [W-1:0] cur, input logic [W-1:0] prv);
    logic [W-1:0] rise, fall;
    rise = cur & ~prv;
    fall = ~cur & prv;
    case (et)
      1:       return rise;
      2:       return fall;
      3:       return rise | fall;
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] view(input logic [1:0] a, input logic [W-1:0] s,
                                       input logic [W-1:0] m, input logic [W-1:0] c);
    case (a)
      2'd0:    return 32'(s);
      2'd2:    return 32'(m);
      2'd3:    return 32'(c);
      default: return 32'h0;
    endcase
  endfunction

  logic         mdl_rst, mdl_wr;
  logic [W-1:0] mdl_clr, mdl_stab;
  logic [W-1:0] mdl_ev [2];

  initial for (int b = 0; b < W; b++) last_flip[b] = 0;

  always @(posedge clk) begin
    if (n < N - 1) begin
      n = n + 1;
      mdl_rst = reset;
      if (mdl_rst) begin
        last_rst    = n;
        model_valid = 1'b1;
      end
      m_hist[n] = mdl_rst ? '0 : in_port;
      m_sync[n] = mdl_rst ? '0 : m_hist[n-1];
`ifdef PIO_DEBOUNCE_EN
      mdl_stab = '0;
      if (!mdl_rst) begin
        for (int b = 0; b < W; b++) begin
          bit flip;
          flip = (n - DB + 1 > last_rst) && (n - DB + 1 > last_flip[b]);
          if (flip)
            for (int k = n - DB + 1; k <= n; k++)
              if (m_sync[k-1][b] == m_stab[n-1][b]) flip = 1'b0;
          mdl_stab[b] = flip ? ~m_stab[n-1][b] : m_stab[n-1][b];
          if (flip) last_flip[b] = n;
        end
      end
      m_stab[n] = mdl_stab;
`else
      m_stab[n] = m_sync[n];
`endif
      mdl_wr  = !mdl_rst && chipselect && !write_n;
      mdl_clr = (mdl_wr && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int i = 0; i < 2; i++) begin
        mdl_ev[i] = (!mdl_rst && n >= 3 && (n - last_rst) > RS)
                  ? edges(i == 0 ? 1 : 3, m_stab[n-1], m_stab[n-2]) : '0;
        m_rd[i][n]  = mdl_rst ? 32'h0 : view(address, m_stab[n-1], m_mask[n-1], m_cap[i][n-1]);
        m_irq[i][n] = mdl_rst ? 1'b0 : |(m_cap[i][n-1] & m_mask[n-1]);
        m_cap[i][n] = mdl_rst ? '0 : ((m_cap[i][n-1] & ~mdl_clr) | mdl_ev[i]);
      end
      m_mask[n] = mdl_rst ? '0 : ((mdl_wr && address == 2'd2) ? writedata[W-1:0] : m_mask[n-1]);
    end
  end

  // Compare on the falling edge, midway between active edges.
  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_rd_rise", rd_a, m_rd[0][n]);
      check("cyc_rd_any", rd_b, m_rd[1][n]);
      check("cyc_irq_rise", 32'(irq_a), 32'(m_irq[0][n]));
      check("cyc_irq_any", 32'(irq_b), 32'(m_irq[1][n]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] va, output logic [31:0] vb);
    address = a;
    tick();
    va = rd_a;
    vb = rd_b;
  endtask

  logic [31:0] va, vb;

  initial begin
    reset = 1'b1; in_port = 5'h1F; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick(3);
    reset = 1'b0;
    tick(10);

    // inputs high out of reset: visible as data, never captured
    rd_reg(2'd0, va, vb); check("t1_data_rise", va, 32'h1F); check("t1_data_any", vb, 32'h1F);
    rd_reg(2'd3, va, vb); check("t1_cap_rise", va, 32'h0);  check("t1_cap_any", vb, 32'h0);
    check("t1_irq", 32'(irq_a), 32'h0);

    in_port = 5'h00; tick(EDGE_LAT + 4);
    rd_reg(2'd3, va, vb); check("t2_fall_rise", va, 32'h0); check("t2_fall_any", vb, 32'h1F);
    in_port = 5'h04; tick(EDGE_LAT + 4);
    rd_reg(2'd3, va, vb); check("t2_cap_rise", va, 32'h04); check("t2_cap_any", vb, 32'h1F);
    check("t2_irq_masked", 32'(irq_a), 32'h0);
    wr_reg(2'd2, 32'h04);
    check("t2_irq_same_cyc", 32'(irq_a), 32'h0);
    tick();
    check("t2_irq_next_cyc", 32'(irq_a), 32'h1);
    check("t2_irq_any", 32'(irq_b), 32'h1);

    wr_reg(2'd3, 32'h00); tick();
    rd_reg(2'd3, va, vb); check("t3_w0_keeps", va, 32'h04);
    wr_reg(2'd3, 32'h04);
    check("t3_irq_lag", 32'(irq_a), 32'h1);
    tick();
    check("t3_irq_clr", 32'(irq_a), 32'h0);
    rd_reg(2'd3, va, vb); check("t3_cap_rise", va, 32'h0); check("t3_cap_any", vb, 32'h1B);

    // rising edge lands on the same clock as a write-1-to-clear of that bit
    in_port = 5'h00; tick(EDGE_LAT + 4);
    in_port = 5'h04; tick(EDGE_LAT);
    wr_reg(2'd3, 32'h04); tick(2);
    rd_reg(2'd3, va, vb); check("t4_edge_wins_rise", va, 32'h04); check("t4_edge_wins_any", vb, 32'h1F);

    wr_reg(2'd3, 32'h1F); tick();
    rd_reg(2'd3, va, vb); check("t5_cleared", va | vb, 32'h0);
    in_port = 5'h05; tick(EDGE_LAT + 4);
    in_port = 5'h04; tick(EDGE_LAT + 4);
    rd_reg(2'd3, va, vb); check("t5_cap_rise", va, 32'h01); check("t5_cap_any", vb, 32'h01);
    rd_reg(2'd1, va, vb); check("t5_reserved", va, 32'h0);
    wr_reg(2'd0, 32'hFFFF_FFFF);
    rd_reg(2'd0, va, vb); check("t5_data_ro", va, 32'h04);
    wr_reg(2'd1, 32'hFFFF_FFFF);
    rd_reg(2'd1, va, vb); check("t5_reserved_wr", vb, 32'h0);
    wr_reg(2'd2, 32'hFFFF_FFFF);
    rd_reg(2'd2, va, vb); check("t5_mask_width", va, 32'h1F);
    address = 2'd2; writedata = 32'h0; write_n = 1'b0; chipselect = 1'b0;
    tick();
    write_n = 1'b1;
    rd_reg(2'd2, va, vb); check("t5_no_cs", va, 32'h1F);

    // reset mid-operation with an input held high
    reset = 1'b1; tick(2);
    reset = 1'b0;
    check("rst_irq", 32'(irq_a), 32'h0);
    tick(EDGE_LAT + 4);
    rd_reg(2'd2, va, vb); check("rst_mask", va, 32'h0);
    rd_reg(2'd3, va, vb); check("rst_cap_rise", va, 32'h0); check("rst_cap_any", vb, 32'h0);
    rd_reg(2'd0, va, vb); check("rst_data", va, 32'h04);

`ifdef PIO_DEBOUNCE_EN
    in_port = 5'h00; tick(DB + 6);
    wr_reg(2'd3, 32'h1F); tick();
    in_port = 5'h02; tick(10);
    in_port = 5'h00; tick(DB + 6);
    rd_reg(2'd3, va, vb); check("db_glitch_cap", va | vb, 32'h0);
    rd_reg(2'd0, va, vb); check("db_glitch_data", va, 32'h0);
    address = 2'd0;
    in_port = 5'h02; tick(18);
    check("db_early", rd_a, 32'h0);
    tick();
    check("db_exact", rd_a, 32'h02);
    tick();
    in_port = 5'h00; tick(DB + 6);
    rd_reg(2'd3, va, vb); check("db_cap_rise", va, 32'h02); check("db_cap_any", vb, 32'h02);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
